traffic_intersection_ctrl: RTL and testbench

Parametrised two-road intersection controller, the next generation of the single-approach `traffic_light` block. It drives independent North-South and East-West signal heads and enforces an all-red clearance interval between conflicting greens. It also services a latched pedestrian request with a walk phase and provides a flashing-yellow maintenance mode. Phase durations are set by parameters; it sits directly under the intersection top level, driven from the system clock.

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/traffic_intersection_ctrl_phase_timer.sv | 28 ++
 rtl/traffic_intersection_ctrl.sv | 152 +++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the two-road intersection controller: FSM states,
// green-direction tag, per-head lamp bundle and small decode helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        AR_NS,
        EW_G,
        EW_Y,
        AR_EW,
        WALK,
        FLASH
    } tl_state_t;

    typedef enum logic {
        NS,
        EW
    } tl_dir_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } tl_lamp_t;

    localparam tl_lamp_t LAMP_RED = '{red: 1'b1, yellow: 1'b0, green: 1'b0};

    function automatic int max_cyc(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // One head's lamps; every state other than its own green/yellow or FLASH shows red.
    function automatic tl_lamp_t head_decode(input tl_state_t st, input tl_state_t own_g,
                                             input tl_state_t own_y, input logic flash_bit);
        tl_lamp_t l;
        l = '{red: 1'b0, yellow: 1'b0, green: 1'b0};
        if (st == own_g)      l.green  = 1'b1;
        else if (st == own_y) l.yellow = 1'b1;
        else if (st == FLASH) l.yellow = flash_bit;
        else                  l.red    = 1'b1;
        return l;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Holds at zero rather than wrapping when it is not reloaded.
module phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with all-red clearance, latched pedestrian
// walk phase and flashing-yellow maintenance mode. Lamps are registered alongside the state.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 5,
    parameter int FLASH_CYC  = 4,
    parameter int CNT_W      = $clog2(max_cyc(GREEN_CYC, YELLOW_CYC, ALLRED_CYC,
                                              WALK_CYC, FLASH_CYC)) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic ped_req,
    input  logic flash_en,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);

    tl_state_t  r_state;
    tl_dir_t    r_next_dir;
    logic       r_ped_pending;
    logic       r_flash;
    tl_lamp_t   r_ns_lamp;
    tl_lamp_t   r_ew_lamp;
    logic       r_walk;

    tl_state_t        w_state_next;
    tl_dir_t          w_next_dir_next;
    logic             w_ped_next;
    logic             w_flash_next;
    logic             w_phase_done;
    logic             w_phase_load;
    logic [CNT_W-1:0] w_phase_load_val;
    logic             w_flash_done;
    logic             w_flash_load;

    phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(ALLRED_CYC - 1))
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_phase_load),
        .i_load_val(w_phase_load_val),
        .o_done    (w_phase_done)
    );

    phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL('0)
    ) u_flash_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_flash_load),
        .i_load_val(CNT_W'(FLASH_CYC - 1)),
        .o_done    (w_flash_done)
    );

    always_comb begin
        w_state_next = r_state;
        if (flash_en) begin
            w_state_next = FLASH;
        end else if (r_state == FLASH) begin
            w_state_next = AR_EW;
        end else if (w_phase_done) begin
            case (r_state)
                NS_G:    w_state_next = NS_Y;
                NS_Y:    w_state_next = AR_NS;
                AR_NS:   w_state_next = r_ped_pending ? WALK : EW_G;
                EW_G:    w_state_next = EW_Y;
                EW_Y:    w_state_next = AR_EW;
                AR_EW:   w_state_next = r_ped_pending ? WALK : NS_G;
                WALK:    w_state_next = (r_next_dir == NS) ? NS_G : EW_G;
                default: w_state_next = AR_EW;
            endcase
        end
    end

    // The phase counter reloads with the duration of whichever state is being entered.
    always_comb begin
        w_phase_load     = (w_state_next != r_state);
        w_phase_load_val = '0;
        case (w_state_next)
            NS_G, EW_G:   w_phase_load_val = CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y:   w_phase_load_val = CNT_W'(YELLOW_CYC - 1);
            AR_NS, AR_EW: w_phase_load_val = CNT_W'(ALLRED_CYC - 1);
            WALK:         w_phase_load_val = CNT_W'(WALK_CYC - 1);
            default:      w_phase_load_val = '0;
        endcase
    end

    always_comb begin
        w_flash_load = (w_state_next == FLASH) && ((r_state != FLASH) || w_flash_done);
        w_flash_next = r_flash;
        if (w_state_next == FLASH) begin
            if (r_state != FLASH)  w_flash_next = 1'b1;
            else if (w_flash_done) w_flash_next = ~r_flash;
        end

        w_next_dir_next = r_next_dir;
        if (w_state_next == AR_NS)      w_next_dir_next = EW;
        else if (w_state_next == AR_EW) w_next_dir_next = NS;

        // A request coinciding with WALK entry is absorbed by that entry.
        w_ped_next = r_ped_pending;
        if (flash_en)
            w_ped_next = 1'b0;
        else if ((w_state_next == WALK) && (r_state != WALK))
            w_ped_next = 1'b0;
        else if (ped_req && (r_state != WALK) && (r_state != FLASH))
            w_ped_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= AR_EW;
            r_next_dir    <= NS;
            r_ped_pending <= 1'b0;
            r_flash       <= 1'b0;
            r_ns_lamp     <= LAMP_RED;
            r_ew_lamp     <= LAMP_RED;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_next_dir    <= w_next_dir_next;
            r_ped_pending <= w_ped_next;
            r_flash       <= w_flash_next;
            r_ns_lamp     <= head_decode(w_state_next, NS_G, NS_Y, w_flash_next);
            r_ew_lamp     <= head_decode(w_state_next, EW_G, EW_Y, w_flash_next);
            r_walk        <= (w_state_next == WALK);
        end
    end

    assign ns_red      = r_ns_lamp.red;
    assign ns_yellow   = r_ns_lamp.yellow;
    assign ns_green    = r_ns_lamp.green;
    assign ew_red      = r_ew_lamp.red;
    assign ew_yellow   = r_ew_lamp.yellow;
    assign ew_green    = r_ew_lamp.green;
    assign walk        = r_walk;
    assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl: default-parameter instance for the
// normal, pedestrian, flash and reset scenarios, plus a minimum-duration instance.
module tb_traffic_intersection_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ped_req, flash_en, reset2;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;
    logic ns_red2, ns_yellow2, ns_green2, ew_red2, ew_yellow2, ew_green2, walk2, ped_pending2;
    logic ped_req2, flash_en2;

    int checks = 0;
    int failures = 0;

    // Lamp vector: {ns r,y,g, ew r,y,g, walk}
    localparam logic [6:0] P_NSG = 7'b001_100_0;
    localparam logic [6:0] P_NSY = 7'b010_100_0;
    localparam logic [6:0] P_AR  = 7'b100_100_0;
    localparam logic [6:0] P_EWG = 7'b100_001_0;
    localparam logic [6:0] P_EWY = 7'b100_010_0;
    localparam logic [6:0] P_WLK = 7'b100_100_1;
    localparam logic [6:0] P_FY  = 7'b010_010_0;
    localparam logic [6:0] P_F0  = 7'b000_000_0;

    logic [6:0] obs, obs2;
    assign obs  = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
    assign obs2 = {ns_red2, ns_yellow2, ns_green2, ew_red2, ew_yellow2, ew_green2, walk2};

    traffic_intersection_ctrl dut (
        .clk(clk), .reset(reset), .ped_req(ped_req), .flash_en(flash_en),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .ped_pending(ped_pending)
    );

    traffic_intersection_ctrl #(
        .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1)
    ) dut_min (
        .clk(clk), .reset(reset2), .ped_req(ped_req2), .flash_en(flash_en2),
        .ns_red(ns_red2), .ns_yellow(ns_yellow2), .ns_green(ns_green2),
        .ew_red(ew_red2), .ew_yellow(ew_yellow2), .ew_green(ew_green2),
        .walk(walk2), .ped_pending(ped_pending2)
    );

    // Normal 26-cycle lap for default parameters, position 0 = first NS_G cycle.
    function automatic logic [6:0] exp_norm(input int tt);
        int m;
        m = tt % 26;
        if (m < 8)  return P_NSG;
        if (m < 11) return P_NSY;
        if (m < 13) return P_AR;
        if (m < 21) return P_EWG;
        if (m < 24) return P_EWY;
        return P_AR;
    endfunction

    function automatic logic [6:0] exp_min(input int tt);
        case (tt % 6)
            0:       return P_NSG;
            1:       return P_NSY;
            2:       return P_AR;
            3:       return P_EWG;
            4:       return P_EWY;
            default: return P_AR;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves dut at the first NS_G cycle.
    task automatic do_reset();
        reset = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        reset = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== P_AR) begin
                failures++;
                $display("FAIL reset_lamps edge=%0d got=%b exp=%b", i, obs, P_AR);
            end
            checks++;
            if (ped_pending !== 1'b0) begin
                failures++;
                $display("FAIL reset_pending edge=%0d got=%b exp=0", i, ped_pending);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (obs !== P_AR) begin
            failures++;
            $display("FAIL post_reset_allred got=%b exp=%b", obs, P_AR);
        end
        step();
        for (int i = 0; i < 52; i++) begin
            checks++;
            if (obs !== exp_norm(i)) begin
                failures++;
                $display("FAIL normal_cycle t=%0d got=%b exp=%b", i, obs, exp_norm(i));
            end
            step();
        end
    endtask

    task automatic test_ped_ew();
        do_reset();
        repeat (13) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int i = 14; i < 26; i++) begin
            checks++;
            if (obs !== exp_norm(i) || ped_pending !== 1'b1) begin
                failures++;
                $display("FAIL ped_ew_pending t=%0d got=%b/%b exp=%b/1", i, obs, ped_pending, exp_norm(i));
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== P_WLK || ped_pending !== 1'b0) begin
                failures++;
                $display("FAIL ped_ew_walk w=%0d got=%b/%b exp=%b/0", i, obs, ped_pending, P_WLK);
            end
            step();
        end
        for (int i = 0; i < 26; i++) begin
            checks++;
            if (obs !== exp_norm(i) || ped_pending !== 1'b0) begin
                failures++;
                $display("FAIL ped_ew_after t=%0d got=%b/%b exp=%b/0", i, obs, ped_pending, exp_norm(i));
            end
            step();
        end
    endtask

    task automatic test_ped_ns();
        do_reset();
        repeat (9) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int i = 10; i < 13; i++) begin
            checks++;
            if (obs !== exp_norm(i) || ped_pending !== 1'b1) begin
                failures++;
                $display("FAIL ped_ns_pending t=%0d got=%b/%b exp=%b/1", i, obs, ped_pending, exp_norm(i));
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== P_WLK) begin
                failures++;
                $display("FAIL ped_ns_walk w=%0d got=%b exp=%b", i, obs, P_WLK);
            end
            step();
        end
        for (int i = 13; i < 30; i++) begin
            checks++;
            if (obs !== exp_norm(i)) begin
                failures++;
                $display("FAIL ped_ns_resume t=%0d got=%b exp=%b", i, obs, exp_norm(i));
            end
            step();
        end
    endtask

    task automatic test_ped_held();
        do_reset();
        repeat (24) step();
        ped_req = 1'b1;
        step();
        checks++;
        if (obs !== P_AR || ped_pending !== 1'b1) begin
            failures++;
            $display("FAIL held_latch got=%b/%b exp=%b/1", obs, ped_pending, P_AR);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== P_WLK || ped_pending !== 1'b0) begin
                failures++;
                $display("FAIL held_walk w=%0d got=%b/%b exp=%b/0", i, obs, ped_pending, P_WLK);
            end
            if (i == 4) ped_req = 1'b0;
            step();
        end
        for (int i = 0; i < 26; i++) begin
            checks++;
            if (obs !== exp_norm(i) || ped_pending !== 1'b0) begin
                failures++;
                $display("FAIL held_single_walk t=%0d got=%b/%b exp=%b/0", i, obs, ped_pending, exp_norm(i));
            end
            step();
        end
    endtask

    task automatic test_flash();
        logic [6:0] e;
        do_reset();
        repeat (2) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (obs !== P_NSG || ped_pending !== 1'b1) begin
            failures++;
            $display("FAIL flash_pre got=%b/%b exp=%b/1", obs, ped_pending, P_NSG);
        end
        flash_en = 1'b1;
        ped_req = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            e = (((i / 4) % 2) == 0) ? P_FY : P_F0;
            checks++;
            if (obs !== e || ped_pending !== 1'b0) begin
                failures++;
                $display("FAIL flash_toggle c=%0d got=%b/%b exp=%b/0", i, obs, ped_pending, e);
            end
            step();
        end
        ped_req = 1'b0;
        flash_en = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== P_AR) begin
                failures++;
                $display("FAIL flash_exit_allred c=%0d got=%b exp=%b", i, obs, P_AR);
            end
            step();
        end
        checks++;
        if (obs !== P_NSG || ped_pending !== 1'b0) begin
            failures++;
            $display("FAIL flash_exit_nsg got=%b/%b exp=%b/0", obs, ped_pending, P_NSG);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (14) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        repeat (6) step();
        checks++;
        if (obs !== P_EWY || ped_pending !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%b/%b exp=%b/1", obs, ped_pending, P_EWY);
        end
        reset = 1'b1;
        step();
        checks++;
        if (obs !== P_AR || ped_pending !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b exp=%b/0", obs, ped_pending, P_AR);
        end
        reset = 1'b0;
        step();
        checks++;
        if (obs !== P_AR) begin
            failures++;
            $display("FAIL mid_allred got=%b exp=%b", obs, P_AR);
        end
        step();
        for (int i = 0; i < 27; i++) begin
            checks++;
            if (obs !== exp_norm(i)) begin
                failures++;
                $display("FAIL mid_restart t=%0d got=%b exp=%b", i, obs, exp_norm(i));
            end
            step();
        end
    endtask

    task automatic test_min_params();
        reset2 = 1'b1;
        step(); step();
        reset2 = 1'b0;
        checks++;
        if (obs2 !== P_AR) begin
            failures++;
            $display("FAIL min_reset got=%b exp=%b", obs2, P_AR);
        end
        step();
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (obs2 !== exp_min(i)) begin
                failures++;
                $display("FAIL min_seq t=%0d got=%b exp=%b", i, obs2, exp_min(i));
            end
            checks++;
            if (ns_green2 === 1'b1 && ew_green2 === 1'b1) begin
                failures++;
                $display("FAIL min_both_green t=%0d got=11 exp=not both", i);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
        reset2 = 1'b1; ped_req2 = 1'b0; flash_en2 = 1'b0;
        test_reset();
        test_ped_ew();
        test_ped_ns();
        test_ped_held();
        test_flash();
        test_reset_mid();
        test_min_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
